// File: rtl/tick_sched_pkg.sv
// Shared types and default sizing for the tick scheduler slice.
package tick_sched_pkg;

  localparam int NUM_CH_DEF = 4;
  localparam int CNT_W_DEF  = 16;

  typedef enum logic {
    G_IDLE  = 1'b0,
    G_OFFER = 1'b1
  } grant_state_t;

endpackage

// File: rtl/tick_channel.sv
// One tick channel: divisor register, reload down-counter, pending and sticky overrun flags.
module tick_channel #(
  parameter int CNT_W = 16
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             run,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_div,
  input  logic             ack,
  input  logic             ovr_clr,
  output logic             pending,
  output logic             overrun
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] div_reg;
  logic [CNT_W-1:0] cnt;
  logic             expire;
  logic             ovr_set;

  assign expire  = run && (div_reg != '0) && (cnt == '0);
  // An ack landing on the expiry cycle hands the slot straight to the new tick.
  assign ovr_set = expire && pending && !ack && !wr;

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      div_reg <= '0;
      cnt     <= '0;
    end else if (wr) begin
      div_reg <= wr_div;
      cnt     <= (wr_div == '0) ? '0 : wr_div - ONE;
    end else if (run && div_reg != '0) begin
      cnt     <= (cnt == '0) ? div_reg - ONE : cnt - ONE;
    end
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset)      pending <= 1'b0;
    else if (wr)     pending <= 1'b0;
    else if (expire) pending <= 1'b1;
    else if (ack)    pending <= 1'b0;
  end

  // A new miss beats a coincident clear.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset)       overrun <= 1'b0;
    else if (ovr_set) overrun <= 1'b1;
    else if (ovr_clr) overrun <= 1'b0;
  end

endmodule

// File: rtl/tick_scheduler.sv
// Periodic tick channels sharing one engine slot via a round-robin grant/ack handshake.
module tick_scheduler
  import tick_sched_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                      clk_in,
  input  logic                      reset,
  input  logic                      run,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [$clog2(NUM_CH)-1:0] cfg_ch,
  input  logic [CNT_W-1:0]          cfg_div,
  output logic                      grant_valid,
  output logic [$clog2(NUM_CH)-1:0] grant_ch,
  input  logic                      grant_ack,
  output logic [NUM_CH-1:0]         overrun,
  input  logic                      ovr_clr
);

  localparam int CH_W = $clog2(NUM_CH);

  grant_state_t      state, state_nxt;
  logic              cfg_blk;
  logic              wr_acc;
  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] ack_vec;
  logic [CH_W-1:0]   rr_ptr;
  logic [CH_W-1:0]   sel;
  logic [CH_W-1:0]   idx;
  logic              sel_vld;

  // Write port takes one write, then rests a cycle.
  assign cfg_ready = ~cfg_blk;
  assign wr_acc    = cfg_valid & cfg_ready;

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) cfg_blk <= 1'b0;
    else        cfg_blk <= wr_acc;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign ack_vec[i] = grant_valid && grant_ack && (grant_ch == CH_W'(i));

    tick_channel #(.CNT_W(CNT_W)) u_ch (
      .clk_in  (clk_in),
      .reset   (reset),
      .run     (run),
      .wr      (wr_acc && (cfg_ch == CH_W'(i))),
      .wr_div  (cfg_div),
      .ack     (ack_vec[i]),
      .ovr_clr (ovr_clr),
      .pending (pending[i]),
      .overrun (overrun[i])
    );
  end

  // Scan from farthest to nearest so the channel right after rr_ptr wins.
  always_comb begin
    sel     = '0;
    sel_vld = 1'b0;
    idx     = '0;
    for (int k = NUM_CH; k >= 1; k--) begin
      idx = CH_W'((int'(rr_ptr) + k) % NUM_CH);
      if (pending[idx]) begin
        sel     = idx;
        sel_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) state <= G_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      G_IDLE:  if (sel_vld)   state_nxt = G_OFFER;
      G_OFFER: if (grant_ack) state_nxt = G_IDLE;
      default:                state_nxt = G_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      grant_ch <= '0;
      rr_ptr   <= CH_W'(NUM_CH - 1);
    end else if (state == G_IDLE && sel_vld) begin
      grant_ch <= sel;
      rr_ptr   <= sel;
    end
  end

  assign grant_valid = (state == G_OFFER);

endmodule

// File: tb/tb_tick_scheduler.sv
// Bench for tick_scheduler: vector table, hand sequences and a grant-order scoreboard.
module tb_tick_scheduler;

  logic        clk_in;
  logic        reset;
  logic        run;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [1:0]  cfg_ch;
  logic [15:0] cfg_div;
  logic        grant_valid;
  logic [1:0]  grant_ch;
  logic        grant_ack;
  logic [3:0]  overrun;
  logic        ovr_clr;

  int n_chk  = 0;
  int n_fail = 0;

  logic [1:0] sb[$];

  typedef struct {
    logic        cv;
    logic [1:0]  ch;
    logic [15:0] div;
    logic        run;
    logic        ack;
    logic        e_rdy;
    logic        e_gv;
    logic [1:0]  e_gch;
    logic [3:0]  e_ovr;
  } vec_t;

  vec_t tv[16];

  tick_scheduler #(.NUM_CH(4), .CNT_W(16)) dut (
    .clk_in      (clk_in),
    .reset       (reset),
    .run         (run),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_ch      (cfg_ch),
    .cfg_div     (cfg_div),
    .grant_valid (grant_valid),
    .grant_ch    (grant_ch),
    .grant_ack   (grant_ack),
    .overrun     (overrun),
    .ovr_clr     (ovr_clr)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0; run = 1'b0; cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0;
    grant_ack = 1'b0; ovr_clr = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    chk("rst.cfg_ready", 32'(cfg_ready), 32'd1);
    chk("rst.grant_valid", 32'(grant_valid), 32'd0);
    chk("rst.grant_ch", 32'(grant_ch), 32'd0);
    chk("rst.overrun", 32'(overrun), 32'd0);
  endtask

  task automatic cfg_write(input logic [1:0] ch, input logic [15:0] div);
    int n = 0;
    while (!cfg_ready && n < 4) begin
      tick();
      n++;
    end
    chk("cfg_ready_wait", 32'(cfg_ready), 32'd1);
    cfg_valid = 1'b1; cfg_ch = ch; cfg_div = div;
    tick();
    cfg_valid = 1'b0;
  endtask

  // Engine model: acks each offer immediately, or one cycle into it when late=1.
  task automatic drain(input int budget, input bit late);
    bit         waited = 1'b0;
    int         cyc = 0;
    logic [1:0] e;
    while (sb.size() > 0 && cyc < budget) begin
      grant_ack = 1'b0;
      if (grant_valid) begin
        if (!late || waited) begin
          grant_ack = 1'b1;
          e = sb.pop_front();
          chk("sb.grant_ch", 32'(grant_ch), 32'(e));
          waited = 1'b0;
        end else begin
          waited = 1'b1;
        end
      end
      tick();
      cyc++;
    end
    grant_ack = 1'b0;
    if (sb.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL sb.timeout: got %0d grants outstanding expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    logic [1:0]  ch_seq[4];
    logic [15:0] div_seq[4];
    reset = 1'b0;

    // Div=4 on ch0 with ack tied high; cfg_valid held 4 cycles (2nd/4th rejected).
    ch_seq  = '{2'd0, 2'd1, 2'd3, 2'd1};
    div_seq = '{16'd4, 16'd3, 16'd0, 16'd3};
    for (int k = 0; k < 16; k++) begin
      tv[k].cv    = (k < 4);
      tv[k].ch    = (k < 4) ? ch_seq[k] : 2'd0;
      tv[k].div   = (k < 4) ? div_seq[k] : 16'd0;
      tv[k].run   = 1'b1;
      tv[k].ack   = 1'b1;
      tv[k].e_rdy = !(k == 1 || k == 3);
      tv[k].e_gv  = (k == 6 || k == 10 || k == 14);
      tv[k].e_gch = 2'd0;
      tv[k].e_ovr = 4'd0;
    end

    do_reset();
    for (int k = 0; k < 16; k++) begin
      cfg_valid = tv[k].cv; cfg_ch = tv[k].ch; cfg_div = tv[k].div;
      run = tv[k].run; grant_ack = tv[k].ack;
      chk($sformatf("A.cfg_ready[%0d]", k), 32'(cfg_ready), 32'(tv[k].e_rdy));
      chk($sformatf("A.grant_valid[%0d]", k), 32'(grant_valid), 32'(tv[k].e_gv));
      chk($sformatf("A.grant_ch[%0d]", k), 32'(grant_ch), 32'(tv[k].e_gch));
      chk($sformatf("A.overrun[%0d]", k), 32'(overrun), 32'(tv[k].e_ovr));
      tick();
    end

    // Two channels in consecutive write slots, late ack: strict alternation.
    do_reset();
    run = 1'b1;
    sb.push_back(2'd0); sb.push_back(2'd1); sb.push_back(2'd0); sb.push_back(2'd1);
    cfg_write(2'd0, 16'd8);
    cfg_write(2'd1, 16'd8);
    drain(80, 1'b1);
    run = 1'b0;
    chk("B.overrun", 32'(overrun), 32'd0);

    // Same-cycle expiry of ch3 and ch0 from reset pointer: 0 first, then 3.
    do_reset();
    sb.push_back(2'd0); sb.push_back(2'd3);
    cfg_write(2'd3, 16'd1);
    cfg_write(2'd0, 16'd1);
    run = 1'b1;
    tick();
    run = 1'b0;
    drain(20, 1'b0);
    repeat (3) begin
      chk("F.idle_after_drain", 32'(grant_valid), 32'd0);
      tick();
    end

    // Stalled engine on ch2, then clear, write-during-offer, harmless ack.
    do_reset();
    run = 1'b1;
    cfg_write(2'd2, 16'd3);
    repeat (10) tick();
    chk("C.grant_valid", 32'(grant_valid), 32'd1);
    chk("C.grant_ch", 32'(grant_ch), 32'd2);
    chk("C.overrun", 32'(overrun), 32'h4);
    run = 1'b0; ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    chk("C.ovr_cleared", 32'(overrun), 32'd0);
    chk("C.drain_while_stopped", 32'(grant_valid), 32'd1);
    cfg_write(2'd2, 16'd0);
    chk("C.offer_kept", 32'(grant_valid), 32'd1);
    chk("C.offer_ch", 32'(grant_ch), 32'd2);
    grant_ack = 1'b1; run = 1'b1;
    tick();
    repeat (3) begin
      chk("C.no_regrant", 32'(grant_valid), 32'd0);
      tick();
    end
    grant_ack = 1'b0;

    // Ack coincident with every expiry keeps pending without overrun.
    do_reset();
    run = 1'b1; grant_ack = 1'b1;
    cfg_write(2'd1, 16'd2);
    for (int k = 1; k <= 12; k++) begin
      chk($sformatf("D.grant_valid[%0d]", k), 32'(grant_valid), 32'(k >= 4 && k % 2 == 0));
      if (k >= 4 && k % 2 == 0)
        chk($sformatf("D.grant_ch[%0d]", k), 32'(grant_ch), 32'd1);
      chk($sformatf("D.overrun[%0d]", k), 32'(overrun), 32'd0);
      tick();
    end

    // ovr_clr colliding with a fresh overrun, then reset mid-offer.
    do_reset();
    run = 1'b1;
    cfg_write(2'd1, 16'd1);
    repeat (2) tick();
    chk("G.overrun_set", 32'(overrun), 32'h2);
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    chk("G.clr_vs_new", 32'(overrun), 32'h2);
    run = 1'b0; ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    chk("G.clr_quiet", 32'(overrun), 32'd0);
    chk("G.offering", 32'(grant_valid), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("E.async_drop", 32'(grant_valid), 32'd0);
    chk("E.cfg_ready", 32'(cfg_ready), 32'd1);
    @(posedge clk_in);
    #1 reset = 1'b1;
    run = 1'b1; grant_ack = 1'b1;
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("E.no_grant[%0d]", k), 32'(grant_valid), 32'd0);
      tick();
    end
    cfg_write(2'd1, 16'd1);
    grant_ack = 1'b0;
    repeat (2) tick();
    chk("E.regrant", 32'(grant_valid), 32'd1);
    chk("E.regrant_ch", 32'(grant_ch), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
